// File: rtl/wb_arbiter.sv
// Two-source register-file writeback arbiter with starvation guard for the long-latency port.
// Optional pending-write scoreboard enabled by defining WB_SCOREBOARD_EN.
module wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [5:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [5:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        iss_valid,
  input  logic [5:0]  iss_addr,
  output logic        iss_ready,
  input  logic [5:0]  rs1_addr,
  input  logic [5:0]  rs2_addr,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        wb_en,
  output logic [5:0]  wb_addr,
  output logic [31:0] write_data
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // Ready is a function of the valids, the arbitration state and rst only, never of data.

  typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} arb_state_t;

  localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

  arb_state_t  state, state_nxt;
  logic [3:0]  wait_cnt, wait_nxt;
  logic        b_lose;
  logic        acc;
  logic [5:0]  acc_addr;
  logic [31:0] acc_data;

  // Register 0 and the upper half of the address space are not backed by storage.
  function automatic logic addr_legal(input logic [5:0] addr);
    return (addr != 6'd0) && !addr[5];
  endfunction

  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!rst) begin
      if (state == PRIO_A) begin
        a_ready = a_valid;
        b_ready = b_valid && !a_valid;
      end else begin
        b_ready = b_valid;
        a_ready = a_valid && !b_valid;
      end
    end
  end

  assign b_lose = b_valid && !b_ready;

  always_comb begin
    state_nxt = state;
    wait_nxt  = b_lose ? wait_cnt + 4'd1 : 4'd0;
    case (state)
      PRIO_A: if (b_lose && (wait_cnt == LIMIT_M1)) state_nxt = PRIO_B;
      PRIO_B: if (b_ready) state_nxt = PRIO_A;
      default: state_nxt = PRIO_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PRIO_A;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  assign acc      = a_ready || b_ready;
  assign acc_addr = b_ready ? b_addr : a_addr;
  assign acc_data = b_ready ? b_data : a_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en      <= 1'b0;
      wb_addr    <= 6'd0;
      write_data <= 32'd0;
    end else begin
      wb_en <= acc && addr_legal(acc_addr);
      if (acc) begin
        wb_addr    <= acc_addr;
        write_data <= acc_data;
      end
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [31:1] sb;
  logic [31:0] iss_dec, clr_dec, rs1_dec, rs2_dec;
  logic        iss_fire;

  function automatic logic [31:0] addr_dec(input logic [5:0] addr);
    return addr_legal(addr) ? (32'd1 << addr[4:0]) : 32'd0;
  endfunction

  assign iss_dec = addr_dec(iss_addr);
  assign clr_dec = b_ready ? addr_dec(b_addr) : 32'd0;
  assign rs1_dec = addr_dec(rs1_addr);
  assign rs2_dec = addr_dec(rs2_addr);

  assign iss_ready = !rst && ((iss_dec[31:1] & sb) == 31'd0);
  assign iss_fire  = iss_valid && iss_ready;
  assign rs1_busy  = |(rs1_dec[31:1] & sb);
  assign rs2_busy  = |(rs2_dec[31:1] & sb);

  // Set is applied after clear so a same-cycle issue to the retiring register keeps it pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb <= 31'd0;
    end else begin
      sb <= (sb & ~clr_dec[31:1]) | (iss_fire ? iss_dec[31:1] : 31'd0);
    end
  end
`else
  assign iss_ready = !rst;
  assign rs1_busy  = 1'b0;
  assign rs2_busy  = 1'b0;
`endif

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, the maximum number of consecutive cycles requester B may wait before forced grant (legal 1..15).
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- a_valid  in  1  pipeline writeback request
- a_addr  in  6  destination register
- a_data  in  32  write data
- a_ready  out  1  A accepted this cycle
- b_valid  in  1  long-latency unit writeback request
- b_addr  in  6  destination register
- b_data  in  32  write data
- b_ready  out  1  B accepted this cycle
- iss_valid  in  1  long-latency op issued; marks iss_addr pending
- iss_addr  in  6  destination of issued op
- iss_ready  out  1  issue accepted
- rs1_addr, rs2_addr  in  6 each  decode read addresses
- rs1_busy, rs2_busy  out  1 each  read address has a pending B write
- wb_en  out  1  register-file write enable
- wb_addr  out  6  register-file write address
- write_data  out  32  register-file write data

Function
REQ-003 SHALL accept at most one request per cycle; a request is accepted when valid and ready are both high on a rising edge.
REQ-004 SHALL use a two-state arbitration FSM: PRIO_A (A wins when both are valid) and PRIO_B (B wins when both are valid).
REQ-005 SHALL grant any lone valid requester in either state.
REQ-006 SHALL keep a 4-bit wait counter, incremented each cycle b_valid is high and B is not accepted, and cleared when B is accepted or b_valid is low.
REQ-007 SHALL transition PRIO_A -> PRIO_B when the wait counter equals STARVE_LIMIT-1 and B loses that cycle.
REQ-008 SHALL transition PRIO_B -> PRIO_A on the cycle B is accepted; otherwise PRIO_B SHALL persist.
REQ-009 SHALL compute a_ready and b_ready combinationally from the valids and the FSM state; ready SHALL not depend on data.
REQ-010 SHALL register the accepted request, driving wb_en/wb_addr/write_data exactly one cycle after acceptance (latency 1).
REQ-011 SHALL drive wb_en low in any cycle following a cycle with no acceptance.
REQ-012 SHALL accept writes whose address is 0 or has addr[5]=1, but SHALL drive wb_en low for them (write dropped, handshake completes).
REQ-013 SHALL keep a 31-bit pending scoreboard for registers 1..31.
REQ-014 SHALL set the scoreboard bit on iss_valid && iss_ready; iss_ready SHALL be low when the iss_addr bit is already set, and high for addresses 0 or addr[5]=1, which set no bit.
REQ-015 SHALL clear the scoreboard bit for b_addr when B is accepted.
REQ-016 SHALL let set win when issue and B acceptance hit the same address in the same cycle; the bit stays set.
REQ-017 SHALL drive rsN_busy = scoreboard bit of rsN_addr, combinationally from current state, and SHALL drive it low for address 0 or addr[5]=1.
REQ-018 SHALL not clear scoreboard bits on A writes.

Reset
REQ-019 SHALL, on rst high at a clock edge, reset the FSM to PRIO_A, the wait counter to 0, all scoreboard bits to 0, wb_en to 0, wb_addr to 0, and write_data to 0.
REQ-020 SHALL discard, when rst is asserted mid-operation, any request accepted in that same cycle, so that wb_en is low in the next cycle.
REQ-021 SHALL hold a_ready, b_ready and iss_ready low while rst is high.

Configuration
REQ-022 SHALL, when macro WB_SCOREBOARD_EN is defined, implement REQ-013..REQ-018.
REQ-023 SHALL, when WB_SCOREBOARD_EN is undefined, omit the scoreboard, tie iss_ready high, and tie rs1_busy and rs2_busy low; arbitration is unchanged.

Verification
REQ-024 SHALL cover: a_valid=1 only with a_addr=5, a_data=0x1234 -> a_ready=1, and next cycle wb_en=1, wb_addr=5, write_data=0x1234.
REQ-025 SHALL cover: a_valid and b_valid held high continuously, STARVE_LIMIT=4 -> A granted cycles 0-3, B granted cycle 4, A again cycle 5.
REQ-026 SHALL cover: iss_valid with iss_addr=7, then rs1_addr=7 -> rs1_busy=1; after B accepted with b_addr=7, next cycle rs1_busy=0; a second issue to 7 while busy -> iss_ready=0.
REQ-027 SHALL cover: B accepted with b_addr=9 while issue to 9 in the same cycle -> bit 9 remains set.
REQ-028 SHALL cover: a_valid with a_addr=0, then a_addr=6'h21 -> a_ready=1 both times and wb_en=0 both following cycles.
REQ-029 SHALL cover: rst asserted in the cycle B is accepted -> next cycle wb_en=0, FSM in PRIO_A, and all busy outputs 0.
